// File: rtl/decode_queue_stage_if.sv
// Fetch-side request and decoded-bundle signals of the decode queue stage.
// The slave modport is the stage itself; the master modport is the surrounding pipeline.
interface decode_queue_stage_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc4;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc4;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [XLEN-1:0]  imm_ext;
    logic [25:0]      target;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             alu_src;
    logic             mem_to_reg;
    logic             is_float;
    logic             reg_dst;
    logic             mfc1;
    logic             mtc1;
    logic [3:0]       alu_op;
    logic [1:0]       jump_src;
    logic             illegal;
    logic [CNT_W-1:0] count;

    modport slave (
        input  flush, in_valid, in_instr, in_pc4, out_ready,
        output in_ready, out_valid, out_pc4, opcode, rs, rt, rd, shamt, funct,
               imm_ext, target, reg_write, mem_read, mem_write, branch, jump,
               alu_src, mem_to_reg, is_float, reg_dst, mfc1, mtc1, alu_op,
               jump_src, illegal, count
    );

    modport master (
        output flush, in_valid, in_instr, in_pc4, out_ready,
        input  in_ready, out_valid, out_pc4, opcode, rs, rt, rd, shamt, funct,
               imm_ext, target, reg_write, mem_read, mem_write, branch, jump,
               alu_src, mem_to_reg, is_float, reg_dst, mfc1, mtc1, alu_op,
               jump_src, illegal, count
    );
endinterface

// File: rtl/decode_queue_stage.sv
// Decode stage: DEPTH-entry instruction FIFO whose head is decoded combinationally
// and captured into a registered output bundle under a valid/ready handshake.
module decode_queue_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    decode_queue_stage_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [XLEN-1:0] imm_ext;
        logic [25:0]     target;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            alu_src;
        logic            mem_to_reg;
        logic            is_float;
        logic            reg_dst;
        logic            mfc1;
        logic            mtc1;
        logic [3:0]      alu_op;
        logic [1:0]      jump_src;
        logic            illegal;
    } bundle_t;

    logic [31:0]      instr_mem [DEPTH];
    logic [XLEN-1:0]  pc4_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             out_valid_q;
    bundle_t          out_q;
    bundle_t          dec;
    logic             push;
    logic             pop;
    logic [31:0]      head_instr;
    logic [XLEN-1:0]  imm_se;
    logic [XLEN-1:0]  imm_ze;
    logic [XLEN-1:0]  imm_lui;

    // A full queue never bypasses: a slot must be freed by a pop first.
    assign bus.in_ready = (count_q < CNT_W'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = (count_q != '0) & (~out_valid_q | bus.out_ready);

    assign head_instr = instr_mem[rd_ptr];
    assign imm_se     = XLEN'($signed(head_instr[15:0]));
    assign imm_ze     = XLEN'(head_instr[15:0]);
    assign imm_lui    = XLEN'($signed({head_instr[15:0], 16'h0000}));

    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            instr_mem[wr_ptr] <= bus.in_instr;
            pc4_mem[wr_ptr]   <= bus.in_pc4;
        end
    end

    always_comb begin
        dec         = '0;
        dec.pc4     = pc4_mem[rd_ptr];
        dec.opcode  = head_instr[31:26];
        dec.rs      = head_instr[25:21];
        dec.rt      = head_instr[20:16];
        dec.rd      = head_instr[15:11];
        dec.shamt   = head_instr[10:6];
        dec.funct   = head_instr[5:0];
        dec.target  = head_instr[25:0];
        dec.imm_ext = imm_se;
        case (head_instr[31:26])
            6'b000000: begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                case (head_instr[5:0])
                    6'b100000, 6'b100001: dec.alu_op = 4'b0001;
                    6'b100010, 6'b100011: dec.alu_op = 4'b0010;
                    6'b111100:            dec.alu_op = 4'b0011;
                    6'b111101:            dec.alu_op = 4'b0100;
                    6'b011000:            dec.alu_op = 4'b0101;
                    6'b100100:            dec.alu_op = 4'b0110;
                    6'b100101:            dec.alu_op = 4'b0111;
                    6'b100111:            dec.alu_op = 4'b1000;
                    6'b100110:            dec.alu_op = 4'b1001;
                    6'b101010:            dec.alu_op = 4'b1010;
                    6'b101011:            dec.alu_op = 4'b1011;
                    6'b000000, 6'b000100: dec.alu_op = 4'b1110;
                    6'b000010, 6'b000011: dec.alu_op = 4'b1111;
                    6'b001000: begin
                        dec.jump      = 1'b1;
                        dec.jump_src  = 2'b10;
                        dec.reg_write = 1'b0;
                    end
                    default: begin
                        dec.reg_write = 1'b0;
                        dec.reg_dst   = 1'b0;
                        dec.illegal   = 1'b1;
                    end
                endcase
            end
            6'b001000, 6'b001001: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 4'b0001;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_ext   = imm_ze;
                dec.alu_op    = (head_instr[27:26] == 2'b00) ? 4'b0110 :
                                (head_instr[27:26] == 2'b01) ? 4'b0111 : 4'b1001;
            end
            6'b001111: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 4'b1100;
                dec.imm_ext   = imm_lui;
            end
            6'b100000: begin
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_op     = 4'b0001;
            end
            6'b101000: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = 4'b0001;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b001010, 6'b001011: begin
                dec.branch = 1'b1;
            end
            6'b000010, 6'b000011: begin
                dec.jump      = 1'b1;
                dec.jump_src  = 2'b01;
                dec.reg_write = head_instr[26];
            end
            default: begin
                // Each of the eight opcodes 110xxx is one float operation, selected by opcode[2:0].
                if (head_instr[31:29] == 3'b110) begin
                    dec.is_float = 1'b1;
                    case (head_instr[28:26])
                        3'b000: begin dec.alu_op = 4'b0001; dec.reg_write = 1'b1; end
                        3'b001: begin dec.alu_op = 4'b0010; dec.reg_write = 1'b1; end
                        3'b010: begin dec.alu_op = 4'b0110; dec.reg_write = 1'b1; end
                        3'b011: dec.alu_op = 4'b0011;
                        3'b100: dec.alu_op = 4'b0100;
                        3'b101: dec.alu_op = 4'b0101;
                        3'b110: begin dec.reg_write = 1'b1; dec.mfc1 = 1'b1; end
                        3'b111: dec.mtc1 = 1'b1;
                    endcase
                end else begin
                    dec.illegal = 1'b1;
                end
            end
        endcase
    end

    // Flush drops both the queue and the output register, discarding any same-cycle push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (pop) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc4    = out_q.pc4;
    assign bus.opcode     = out_q.opcode;
    assign bus.rs         = out_q.rs;
    assign bus.rt         = out_q.rt;
    assign bus.rd         = out_q.rd;
    assign bus.shamt      = out_q.shamt;
    assign bus.funct      = out_q.funct;
    assign bus.imm_ext    = out_q.imm_ext;
    assign bus.target     = out_q.target;
    assign bus.reg_write  = out_q.reg_write;
    assign bus.mem_read   = out_q.mem_read;
    assign bus.mem_write  = out_q.mem_write;
    assign bus.branch     = out_q.branch;
    assign bus.jump       = out_q.jump;
    assign bus.alu_src    = out_q.alu_src;
    assign bus.mem_to_reg = out_q.mem_to_reg;
    assign bus.is_float   = out_q.is_float;
    assign bus.reg_dst    = out_q.reg_dst;
    assign bus.mfc1       = out_q.mfc1;
    assign bus.mtc1       = out_q.mtc1;
    assign bus.alu_op     = out_q.alu_op;
    assign bus.jump_src   = out_q.jump_src;
    assign bus.illegal    = out_q.illegal;
endmodule
